// File: rtl/axi_burst_write_arbiter.sv
// axi_burst_write_arbiter: round-robin arbiter sharing one AXI4 write port between two
// requesters, each issuing one fixed-length INCR burst per request.
module axi_burst_write_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_BURST_LEN      = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [1:0]                    req,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   req_addr0,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   req_addr1,
    output logic [1:0]                    gnt,
    output logic [1:0]                    done,
    output logic                          err,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_data0,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_data1,
    input  logic [1:0]                    s_valid,
    output logic [1:0]                    s_ready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);
    localparam int CW = $clog2(C_BURST_LEN);
    localparam int AB = $clog2(C_BURST_LEN * C_AXI_DATA_WIDTH / 8);
    // Aligning to the burst size keeps every burst inside one 4 KB page
    localparam logic [C_AXI_ADDR_WIDTH-1:0] AMASK = {C_AXI_ADDR_WIDTH{1'b1}} << AB;
    localparam logic [CW-1:0] LAST = CW'(C_BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state;
    logic          sel;
    logic          last_grant;
    logic          win;
    logic          in_data;
    logic [CW-1:0] count;

    assign win           = (req[0] & req[1]) ? ~last_grant : req[1];
    assign in_data       = state == DATA;
    assign m_axi_awlen   = 8'(C_BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(C_AXI_DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = in_data & s_valid[sel];
    assign s_ready       = {2{in_data & m_axi_wready}} & (sel ? 2'b10 : 2'b01);
    assign m_axi_wdata   = in_data ? (sel ? s_data1 : s_data0) : '0;
    assign m_axi_wlast   = in_data & (count == LAST);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            gnt           <= '0;
            done          <= '0;
            err           <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_bready  <= 1'b0;
            count         <= '0;
            sel           <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    sel           <= win;
                    gnt           <= win ? 2'b10 : 2'b01;
                    m_axi_awaddr  <= (win ? req_addr1 : req_addr0) & AMASK;
                    m_axi_awvalid <= 1'b1;
                    state         <= ADDR;
                end
                ADDR: if (m_axi_awready) begin
                    m_axi_awvalid <= 1'b0;
                    state         <= DATA;
                end
                DATA: if (m_axi_wvalid && m_axi_wready) begin
                    count <= m_axi_wlast ? '0 : count + 1'b1;
                    if (m_axi_wlast) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    done         <= gnt;
                    err          <= |m_axi_bresp;
                    last_grant   <= sel;
                    gnt          <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_write_arbiter.sv
// tb_axi_burst_write_arbiter: vector table, corner sequences and random bursts checked
// against a round-robin / AXI slave reference model.
module tb_axi_burst_write_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  req;
    logic [31:0] req_addr0, req_addr1;
    logic [1:0]  gnt, done;
    logic        err;
    logic [31:0] s_data0, s_data1;
    logic [1:0]  s_valid, s_ready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_burst_write_arbiter #(
        .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .C_BURST_LEN(8)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .gnt(gnt), .done(done), .err(err), .s_data0(s_data0), .s_data1(s_data1),
        .s_valid(s_valid), .s_ready(s_ready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [1:0]  bresp;
        int          mode;
        logic [1:0]  gnt;
        logic [31:0] aw;
        logic        e;
    } vec_t;

    int          checks = 0, errors = 0, cyc = 0, mode = 0, beat = 0;
    int          bursts_left[2], burst_n[2];
    logic [1:0]  bresp_cfg, exp_gnt, exp_done, prev_gnt;
    logic        exp_gnt_v, exp_err, ref_last, b_pending, aw_seen;
    logic [31:0] exp_aw, wr_addr;
    logic [31:0] src0[$], src1[$];
    logic [1:0]  gnt_log[$];
    logic [31:0] aw_log[$];
    logic        err_log[$];
    logic [31:0] mem[int];
    vec_t        vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_val(input int i, input int n, input int k);
        return 32'((i << 12) | ((n % 16) << 8) | (k + 1));
    endfunction

    task automatic load(input int i);
        for (int k = 0; k < 8; k++)
            if (i == 1) src1.push_back(beat_val(1, burst_n[1], k));
            else src0.push_back(beat_val(0, burst_n[0], k));
    endtask

    task automatic start(input int i, input int n);
        bursts_left[i] = n;
        if (n > 0) load(i);
    endtask

    task automatic reset_model();
        src0.delete(); src1.delete();
        b_pending = 0; aw_seen = 0; beat = 0; exp_done = 0; exp_err = 0;
        exp_gnt_v = 0; ref_last = 1; prev_gnt = 0; req = 0;
        bursts_left[0] = 0; bursts_left[1] = 0;
    endtask

    task automatic sample();
        int  i;
        logic w;
        chk("gnt_onehot", gnt == 2'b11, 0);
        chk("s_ready_granted_only", s_ready & ~gnt, 0);
        chk("w_after_aw", wvalid && !aw_seen, 0);
        if (exp_gnt_v) chk("grant", gnt, exp_gnt);
        exp_gnt_v = 0;
        if (gnt != 0 && prev_gnt == 0) gnt_log.push_back(gnt);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        if (exp_done != 0) begin
            i = exp_done[1] ? 1 : 0;
            chk("beats_per_burst", beat, 8);
            err_log.push_back(err);
            ref_last = exp_done[1];
            burst_n[i]++;
            bursts_left[i]--;
            beat = 0;
            aw_seen = 0;
            if (bursts_left[i] > 0) load(i);
            req[i] = bursts_left[i] > 0;
        end
        exp_done = 0;
        exp_err = 0;
        if (awvalid && awready) begin
            chk("awaddr", awaddr, exp_aw);
            chk("awlen", awlen, 7);
            chk("awsize", awsize, 2);
            chk("awburst", awburst, 1);
            aw_log.push_back(awaddr);
            wr_addr = awaddr;
            aw_seen = 1;
        end
        if (wvalid && wready) begin
            i = gnt[1] ? 1 : 0;
            chk("wdata", wdata, beat_val(i, burst_n[i], beat));
            chk("wlast", wlast, beat == 7);
            chk("wstrb", wstrb, 4'hF);
            chk("s_handshake", s_valid[i] && s_ready[i], 1);
            mem[int'(wr_addr >> 2) + beat] = wdata;
            beat++;
            if (i == 1) void'(src1.pop_front());
            else void'(src0.pop_front());
            if (wlast) b_pending = 1;
        end
        if (bvalid && bready) begin
            b_pending = 0;
            exp_done = gnt;
            exp_err = bresp_cfg != 0;
        end
        // An idle arbiter (no grant held) decides at the coming edge from the current requests
        if (gnt == 0) begin
            exp_gnt_v = 1;
            exp_gnt = 0;
            if (req != 0) begin
                w = (req == 2'b11) ? ~ref_last : req[1];
                exp_gnt = w ? 2'b10 : 2'b01;
                exp_aw = (w ? req_addr1 : req_addr0) & 32'hFFFF_FFE0;
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic step();
        @(negedge ACLK);
        cyc++;
        req[0] = bursts_left[0] > 0;
        req[1] = bursts_left[1] > 0;
        awready = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
        wready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
        bvalid = b_pending && (mode != 2 || 1'($urandom_range(1, 0)));
        bresp = bresp_cfg;
        s_valid[0] = (src0.size() > 0) && (mode == 0 || $urandom_range(2, 0) != 0);
        s_valid[1] = (src1.size() > 0) && (mode == 0 || $urandom_range(2, 0) != 0);
        s_data0 = (src0.size() > 0) ? src0[0] : $urandom;
        s_data1 = (src1.size() > 0) ? src1[0] : $urandom;
        if (mode == 2 && gnt != 0) begin
            req_addr0 = $urandom;
            req_addr1 = $urandom;
        end
        #1;
        sample();
    endtask

    task automatic run(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while ((bursts_left[0] > 0 || bursts_left[1] > 0 || gnt != 0 || exp_done != 0) && n < 3000);
        chk({name, "_timeout"}, n >= 3000, 0);
    endtask

    task automatic clear_logs();
        gnt_log.delete(); aw_log.delete(); err_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, n;
        vt[0] = '{2'b11, 32'h0000_0000, 32'h0000_0020, 2'd0, 0, 2'b01, 32'h0000_0000, 1'b0};
        vt[1] = '{2'b01, 32'h0000_003C, 32'h0000_0000, 2'd2, 0, 2'b01, 32'h0000_0020, 1'b1};
        vt[2] = '{2'b11, 32'h0000_0044, 32'h1234_5678, 2'd0, 0, 2'b10, 32'h1234_5660, 1'b0};
        vt[3] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 2'd3, 1, 2'b10, 32'hFFFF_FFE0, 1'b1};
        vt[4] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 2'd0, 2, 2'b01, 32'h0000_0100, 1'b0};
        vt[5] = '{2'b01, 32'h0000_07FF, 32'h0000_0000, 2'd1, 0, 2'b01, 32'h0000_07E0, 1'b1};
        ARESETN = 0; req_addr0 = 0; req_addr1 = 0; s_valid = 0; s_data0 = 0; s_data1 = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bresp_cfg = 0; wr_addr = 0; exp_aw = 0;
        exp_gnt = 0; burst_n[0] = 0; burst_n[1] = 0;
        reset_model();
        #12;
        chk("reset_outputs", {gnt, done, err, s_ready, awvalid, wvalid, wlast, bready}, 0);
        chk("reset_awaddr", awaddr, 0);
        @(negedge ACLK) ARESETN = 1;

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            req_addr0 = vt[v].a0; req_addr1 = vt[v].a1;
            bresp_cfg = vt[v].bresp; mode = vt[v].mode;
            for (int i = 0; i < 2; i++) if (vt[v].req[i]) start(i, 1);
            run($sformatf("v%0d", v));
            chk($sformatf("v%0d_bursts", v), gnt_log.size(), $countones(vt[v].req));
            chk($sformatf("v%0d_first_gnt", v), gnt_log.size() > 0 ? gnt_log[0] : 2'b00, vt[v].gnt);
            chk($sformatf("v%0d_first_awaddr", v), aw_log.size() > 0 ? aw_log[0] : 32'hDEAD_BEEF, vt[v].aw);
            chk($sformatf("v%0d_first_err", v), err_log.size() > 0 ? err_log[0] : 1'bx, vt[v].e);
            if (v == 0)
                for (int k = 0; k < 8; k++) chk($sformatf("readback%0d", k), mem[k], 32'(k + 1));
        end

        mode = 1; bresp_cfg = 0; req_addr0 = 32'h400; req_addr1 = 32'h800;
        start(0, 1); start(1, 1);
        run("stall");

        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(2, 0);
            bresp_cfg = 2'($urandom_range(3, 0));
            req_addr0 = $urandom; req_addr1 = $urandom;
            n0 = $urandom_range(2, 0);
            n1 = $urandom_range(2, n0 == 0 ? 1 : 0);
            start(0, n0); start(1, n1);
            run($sformatf("rand%0d", r));
        end

        mode = 0; bresp_cfg = 0; req_addr0 = 32'h40;
        start(0, 1);
        n = 0;
        while (beat < 4 && n < 200) begin
            step();
            n++;
        end
        chk("midburst_timeout", n >= 200, 0);
        @(posedge ACLK);
        #2 ARESETN = 0;
        #1;
        chk("async_reset_outputs", {gnt, done, err, s_ready, awvalid, wvalid, wlast, bready}, 0);
        chk("async_reset_awaddr", awaddr, 0);
        reset_model();
        burst_n[0]++;
        @(negedge ACLK) ARESETN = 1;

        clear_logs();
        req_addr0 = 32'h0; req_addr1 = 32'h20;
        start(0, 2); start(1, 2);
        run("alternate");
        chk("alternate_count", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("alternate_order%0d", k), gnt_log.size() > k ? gnt_log[k] : 2'b00,
                (k % 2 == 1) ? 2'b10 : 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_write_arbiter.md
Name: axi_burst_write_arbiter

Overview:
Shares the AXI4 write path into the myip sample buffer between two requesters, for example two hydrophone acquisition channels. Each requester asks for one fixed-length INCR burst. The block arbitrates round-robin, issues the AW channel, streams the winner's beats onto the W channel and collects the B response. It sits between the acquisition front ends and the AXI4 slave port of myip, clocked on the AXI domain.

Parameters:
C_AXI_ADDR_WIDTH, 32, AXI address width
C_AXI_DATA_WIDTH, 32, AXI/stream data width (32 or 64)
C_BURST_LEN, 8, beats per burst (power of two, 2..256)

Ports:
ACLK  in  1  AXI clock, all logic rising-edge
ARESETN  in  1  asynchronous active-low reset
req  in  2  per-requester burst request; held high until matching done
req_addr0  in  C_AXI_ADDR_WIDTH  requester 0 burst base byte address
req_addr1  in  C_AXI_ADDR_WIDTH  requester 1 burst base byte address
gnt  out  2  one-hot grant, high from acceptance through B response
done  out  2  one-cycle pulse on burst completion, per requester
err  out  1  one-cycle pulse with done when BRESP != OKAY
s_data0, s_data1  in  C_AXI_DATA_WIDTH  requester beat data
s_valid  in  2  per-requester beat valid
s_ready  out  2  per-requester beat ready
m_axi_awaddr  out  C_AXI_ADDR_WIDTH  burst address
m_axi_awlen  out  8  constant C_BURST_LEN-1
m_axi_awsize  out  3  constant clog2(C_AXI_DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid / m_axi_awready  out / in  1  AW handshake
m_axi_wdata  out  C_AXI_DATA_WIDTH  selected s_data
m_axi_wstrb  out  C_AXI_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  high on final beat
m_axi_wvalid / m_axi_wready  out / in  1  W handshake
m_axi_bresp  in  2  write response
m_axi_bvalid / m_axi_bready  in / out  1  B handshake

Behaviour:
- Reset (async assert, sync release): state=IDLE. gnt, done, err, s_ready, awvalid, wvalid, wlast and bready are all 0. awaddr=0. Beat counter=0. last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any req is high, pick the winner round-robin. The requester not equal to last_grant has priority when both are high; a lone request wins outright. Register gnt one-hot. Register awaddr = req_addrN with the low clog2(C_BURST_LEN*C_AXI_DATA_WIDTH/8) bits forced to 0. This alignment keeps every burst inside a 4 KB page. Next state is ADDR; awvalid rises on the cycle after the req is sampled.
- ADDR: hold awvalid and awaddr stable until awready. On the handshake cycle, drop awvalid and go to DATA. W is never driven before the AW handshake completes.
- DATA:
  - m_axi_wvalid = s_valid[sel]; s_ready[sel] = m_axi_wready. Both are combinational and gated by state==DATA. The non-selected s_ready is 0.
  - wdata = s_data[sel].
  - The beat counter increments on each wvalid&&wready.
  - wlast = (count == C_BURST_LEN-1).
  - On the last handshake: clear the counter, go to RESP.
- RESP: bready=1. On bvalid:
  - pulse done[sel] for 1 cycle;
  - pulse err if bresp != 2'b00;
  - last_grant = sel;
  - gnt returns to 0 on the next cycle;
  - go to IDLE.
- Minimum gap between bursts: IDLE costs one cycle, so arbitration starts the cycle after gnt drops.
- req deasserted mid-burst is ignored; the burst runs to completion.
- req changes on the non-granted requester during a burst only affect the next arbitration.
- req_addr is sampled only in IDLE.
- Bubbles in s_valid or wready stall the counter; no beat is lost or duplicated.
- Asynchronous reset mid-burst abandons the transaction immediately and all outputs take their reset values. The downstream slave is reset by the same ARESETN.

Test Plan:
1. Reset, then req[0]=1 with addr 0 and stream beats 1..8 with no stalls -> AW addr 0x0, len 7, size 2, burst 1. Exactly 8 W beats carry 1..8 with wlast on beat 8. done[0] pulses once, err=0. Read back via AXI4_READ_BURST: 1..8 match.
2. req=2'b11 asserted in the same cycle out of reset, with addrs 0x00 and 0x20 -> requester 0 burst completes first, then requester 1. gnt is never both set. done[0] precedes done[1].
3. Both reqs held high for 4 bursts -> grant order 0,1,0,1.
4. wready low 2 of every 3 cycles plus random s_valid gaps -> still exactly 8 beats in order, wlast only on the 8th, and s_ready only to the granted requester.
5. req_addr0=0x3C -> awaddr=0x20. Slave returns SLVERR -> err and done[0] pulse together.
6. ARESETN dropped after beat 4 -> all outputs 0 within the same cycle. After release, a new req[0] burst completes normally with last_grant back at reset value.
